prng_seq_ctrl: RTL and testbench

Controller that owns the 3-stage serial XOR-feedback bit generator (ports ena, seed, rst, out; generator reset is synchronous, active-high) and sequences it for a single requester. On a seeded request it clears the generator, shifts the seed in serially, runs it for OUT_W cycles, and packs the output bits into a word. The result is returned over a valid/ready response channel. It sits between a software/test requester and the generator instance.

---
 rtl/prng_seq_pkg.sv | 15 +
 rtl/prng_seq_ctrl.sv | 85 ++++++++
 tb/tb_prng_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/prng_seq_pkg.sv
// Shared types and defaults for the PRNG sequencing controller.
package prng_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SEED  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int SEED_W_DEF = 3;
    localparam int OUT_W_DEF  = 8;

endpackage

// File: rtl/prng_seq_ctrl.sv
// Sequences a 3-stage serial XOR-feedback generator: clear, shift seed in,
// run OUT_W cycles collecting output bits, then hand the word back.
module prng_seq_ctrl
    import prng_seq_pkg::*;
#(
    parameter int SEED_W = SEED_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEED_W-1:0] req_seed,
    input  logic              abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OUT_W-1:0]  rsp_data,
    output logic              busy,
    output logic              gen_rst,
    output logic              gen_ena,
    output logic              gen_seed,
    input  logic              gen_out
);

    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam int IDX_W = $clog2(OUT_W);
    localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SEED_W - 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_W - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [SEED_W-1:0] seed_q;
    logic              accept, abort_take;

    assign accept     = (state == IDLE) && req_valid;
    assign abort_take = abort && ((state == CLEAR) || (state == SEED) || (state == RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid) state_nxt = CLEAR;
            CLEAR: state_nxt = abort ? IDLE : SEED;
            SEED:  if (abort) state_nxt = IDLE;
                   else if (cnt == SEED_LAST) state_nxt = RUN;
            RUN:   if (abort) state_nxt = IDLE;
                   else if (cnt == OUT_LAST) state_nxt = DONE;
            DONE:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Generator controls are decoded straight from state so they act this cycle.
    always_comb begin
        req_ready = rst_n && (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == DONE);
        gen_rst   = !rst_n || (state == CLEAR);
        gen_ena   = (state == RUN);
        gen_seed  = (state == SEED) && seed_q[SEED_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            seed_q   <= '0;
            rsp_data <= '0;
        end else begin
            if (state_nxt != state)                  cnt <= '0;
            else if (state == SEED || state == RUN)  cnt <= cnt + CNT_W'(1);

            // Seed leaves MSB first, so shift left after each SEED cycle.
            if (accept)              seed_q <= req_seed;
            else if (state == SEED)  seed_q <= {seed_q[SEED_W-2:0], 1'b0};

            if (accept || abort_take) rsp_data <= '0;
            else if (state == RUN)    rsp_data[cnt[IDX_W-1:0]] <= gen_out;
        end
    end

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Bench for prng_seq_ctrl: generator alongside, timeline model, directed vectors.
module tb_prng_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, req_valid, req_ready, abort, rsp_valid, rsp_ready;
    logic [2:0] req_seed;
    logic [7:0] rsp_data;
    logic       busy, gen_rst, gen_ena, gen_seed, gen_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prng_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_seed(req_seed), .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .gen_rst(gen_rst), .gen_ena(gen_ena),
        .gen_seed(gen_seed), .gen_out(gen_out)
    );

    // Generator: sync active-high reset; serial load when idle, XOR feedback when enabled.
    logic g_q0, g_q1;
    always @(posedge clk) begin
        if (gen_rst)      {gen_out, g_q1, g_q0} <= 3'b000;
        else if (gen_ena) {gen_out, g_q1, g_q0} <= {g_q1, g_q0, g_q0 ^ g_q1};
        else              {gen_out, g_q1, g_q0} <= {g_q1, g_q0, gen_seed};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word from the documented output series: s2,s1,s0, then x[n]=x[n-1]^x[n-2].
    function automatic logic [7:0] exp_word(input logic [2:0] s);
        logic [10:0] x;
        x[0] = s[2]; x[1] = s[1]; x[2] = s[0];
        for (int k = 3; k < 8; k++) x[k] = x[k-1] ^ x[k-2];
        return x[7:0];
    endfunction

    // Model: phase = edges since acceptance (-1 idle). 0 clear, 1..3 seed, 4..11 run, 12 done.
    int         m_phase;
    logic [2:0] m_seed;
    logic [7:0] m_word, m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= -1;
            m_data  <= 8'h00;
            m_seed  <= 3'b000;
            m_word  <= 8'h00;
        end else if (m_phase < 0) begin
            if (req_valid) begin
                m_phase <= 0;
                m_seed  <= req_seed;
                m_word  <= exp_word(req_seed);
                m_data  <= 8'h00;
            end
        end else if (m_phase < 12) begin
            if (abort) begin
                m_phase <= -1;
                m_data  <= 8'h00;
            end else begin
                m_phase <= m_phase + 1;
                if (m_phase + 1 == 12) m_data <= m_word;
            end
        end else if (rsp_ready) begin
            m_phase <= -1;
        end
    end

    always @(negedge clk) begin
        int         cap;
        logic [7:0] e_data;
        logic       e_seed;
        cap = (m_phase > 4) ? m_phase - 4 : 0;
        if (cap > 8) cap = 8;
        if (m_phase < 0 || m_phase >= 12) e_data = m_data;
        else                              e_data = m_word & 8'((9'd1 << cap) - 9'd1);
        e_seed = (m_phase >= 1 && m_phase <= 3) ? m_seed[3 - m_phase] : 1'b0;
        chk("req_ready", 32'(req_ready), 32'(rst_n && m_phase < 0));
        chk("busy",      32'(busy),      32'(m_phase >= 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 12));
        chk("gen_rst",   32'(gen_rst),   32'(!rst_n || m_phase == 0));
        chk("gen_ena",   32'(gen_ena),   32'(m_phase >= 4 && m_phase <= 11));
        chk("gen_seed",  32'(gen_seed),  32'(e_seed));
        chk("rsp_data",  32'(rsp_data),  32'(e_data));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_req(input logic [2:0] s, input logic [7:0] exp, input int stall, input bit poke);
        int lat, n_ena, n_rst;
        req_valid = 1'b1;
        req_seed  = s;
        step();
        req_valid = 1'b0;
        req_seed  = ~s;
        lat = 0; n_ena = 0; n_rst = 0;
        while (!rsp_valid && lat < 40) begin
            n_ena += 32'(gen_ena);
            n_rst += 32'(gen_rst);
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd12);
        chk("word", 32'(rsp_data), 32'(exp));
        chk("ena_cycles", 32'(n_ena), 32'd8);
        chk("rst_cycles", 32'(n_rst), 32'd1);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                abort     = 1'b1;
                req_valid = 1'b1;
            end
            step();
            chk("stall_data", 32'(rsp_data), 32'(exp));
            chk("stall_valid", 32'(rsp_valid), 32'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        abort     = 1'b0;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_seed = 3'b000; abort = 1'b0; rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_gen_rst",   32'(gen_rst),   32'd1);
        rst_n = 1'b1;
        #1 chk("rel_req_ready", 32'(req_ready), 32'd1);
        step();

        chk("model_101", 32'(exp_word(3'b101)), 32'h6D);
        chk("model_011", 32'(exp_word(3'b011)), 32'hB6);
        chk("model_100", 32'(exp_word(3'b100)), 32'h01);

        // Stall in DONE with abort and a fresh request both ignored.
        run_req(3'b101, 8'h6D, 5, 1'b1);
        run_req(3'b011, 8'hB6, 0, 1'b0);
        run_req(3'b100, 8'h01, 0, 1'b0);
        run_req(3'b000, 8'h00, 2, 1'b0);

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_ready", 32'(req_ready), 32'd1);

        // Abort after four RUN captures.
        req_valid = 1'b1; req_seed = 3'b011;
        step();
        req_valid = 1'b0;
        repeat (8) step();
        chk("partial_data", 32'(rsp_data), 32'h06);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(rsp_data), 32'd0);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("abort_no_valid", 32'(rsp_valid), 32'd0);
        end
        run_req(3'b101, 8'h6D, 0, 1'b0);

        // Asynchronous reset pulse between edges while in SEED.
        req_valid = 1'b1; req_seed = 3'b110;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("seed_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_busy",  32'(busy),      32'd0);
        chk("async_grst",  32'(gen_rst),   32'd1);
        chk("async_valid", 32'(rsp_valid), 32'd0);
        chk("async_data",  32'(rsp_data),  32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        #1 rst_n = 1'b1;
        step();
        run_req(3'b110, 8'hDB, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
